// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller.
package btb_pkg;

  localparam int BTB_ADDR_W = 16;
  localparam int BTB_IDX_W  = 4;

  // Value the BTB treats as an empty entry.
  localparam logic [BTB_ADDR_W-1:0] BTB_INVALID = 16'h0001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } btb_state_e;

  typedef struct packed {
    logic [BTB_IDX_W-1:0]  idx;
    logic [BTB_ADDR_W-1:0] data;
  } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO of pending BTB corrections; push and pop may share a cycle.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  btb_upd_t push_data,
  input  logic     pop,
  output btb_upd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  btb_upd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Control registers; reset drops every queued entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only read while cnt_q says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer and front-end redirect generator.
// Optional statistics counters are built when BTB_CTRL_STATS_EN is defined.
//
// state    | meaning
// ST_IDLE  | drain queued corrections, or write a fresh correction straight through
// ST_SWEEP | invalidate every BTB entry, one index per cycle
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int ADDR_W     = BTB_ADDR_W,
  parameter int IDX_W      = BTB_IDX_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_from_pc,
  input  logic [ADDR_W-1:0] res_to_pc,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_pred_pc,
  output logic              res_ready,
  input  logic              inv_req,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              btb_wr_en,
  output logic [IDX_W-1:0]  btb_wr_idx,
  output logic [ADDR_W-1:0] btb_wr_data,
  output logic              busy,
  output logic [15:0]       stat_resolved,
  output logic [15:0]       stat_mispred
);

  btb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              flush_if_q, flush_if_d;
  logic              wr_en_q, wr_en_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;

  logic              accept, mispred;
  logic [ADDR_W-1:0] actual;
  btb_upd_t          new_upd, head_upd;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign res_ready = !fifo_full;
  assign accept    = res_valid && res_ready;
  assign actual    = res_taken ? res_to_pc : res_from_pc + ADDR_W'(4);
  assign mispred   = (actual != res_pred_pc);

  // A not-taken mispredict means the BTB hit on a stale entry, so it is cleared.
  always_comb begin
    new_upd.idx  = res_from_pc[IDX_W+1:2];
    new_upd.data = res_taken ? res_to_pc : ADDR_W'(BTB_INVALID);
  end

  btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (new_upd),
    .pop       (fifo_pop),
    .pop_data  (head_upd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next state, redirect and write-port arbitration.
  always_comb begin
    state_d          = state_q;
    sweep_cnt_d      = sweep_cnt_q;
    redirect_valid_d = accept && mispred;
    flush_if_d       = accept && mispred;
    redirect_pc_d    = (accept && mispred) ? actual : redirect_pc_q;
    wr_en_d          = 1'b0;
    wr_idx_d         = wr_idx_q;
    wr_data_d        = wr_data_q;
    busy_d           = 1'b0;
    fifo_push        = accept && mispred;
    fifo_pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inv_req) begin
          // Index 0 is written on the entry edge so the sweep starts the next cycle.
          state_d     = ST_SWEEP;
          sweep_cnt_d = IDX_W'(1);
          wr_en_d     = 1'b1;
          wr_idx_d    = '0;
          wr_data_d   = ADDR_W'(BTB_INVALID);
          busy_d      = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          wr_en_d   = 1'b1;
          wr_idx_d  = head_upd.idx;
          wr_data_d = head_upd.data;
        end else if (accept && mispred) begin
          // Empty queue: bypass it so the write lands one cycle after acceptance.
          fifo_push = 1'b0;
          wr_en_d   = 1'b1;
          wr_idx_d  = new_upd.idx;
          wr_data_d = new_upd.data;
        end
      end
      ST_SWEEP: begin
        wr_en_d     = 1'b1;
        wr_idx_d    = sweep_cnt_q;
        wr_data_d   = ADDR_W'(BTB_INVALID);
        busy_d      = 1'b1;
        sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
        if (sweep_cnt_q == '1) state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      sweep_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_if_q       <= 1'b0;
      wr_en_q          <= 1'b0;
      wr_idx_q         <= '0;
      wr_data_q        <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      sweep_cnt_q      <= sweep_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_if_q       <= flush_if_d;
      wr_en_q          <= wr_en_d;
      wr_idx_q         <= wr_idx_d;
      wr_data_q        <= wr_data_d;
      busy_q           <= busy_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_if       = flush_if_q;
  assign btb_wr_en      = wr_en_q;
  assign btb_wr_idx     = wr_idx_q;
  assign btb_wr_data    = wr_data_q;
  assign busy           = busy_q;

`ifdef BTB_CTRL_STATS_EN
  logic [15:0] stat_resolved_q, stat_resolved_d;
  logic [15:0] stat_mispred_q, stat_mispred_d;

  // Saturating event counters.
  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (accept && stat_resolved_q != 16'hFFFF)          stat_resolved_d = stat_resolved_q + 16'd1;
    if (accept && mispred && stat_mispred_q != 16'hFFFF) stat_mispred_d  = stat_mispred_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: expected redirects and BTB writes are
// queued as stimulus is driven and matched as the DUT produces them.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [15:0] res_from_pc, res_to_pc, res_pred_pc;
  logic        res_taken;
  logic        res_ready;
  logic        inv_req;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush_if;
  logic        btb_wr_en;
  logic [3:0]  btb_wr_idx;
  logic [15:0] btb_wr_data;
  logic        busy;
  logic [15:0] stat_resolved, stat_mispred;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } wr_exp_t;

  logic [15:0] redir_q [$];
  wr_exp_t     wr_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_cycles = 0;
  int          exp_res = 0;
  int          exp_mis = 0;
  logic [15:0] mon_pc;
  wr_exp_t     mon_wr;

  btb_update_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .res_valid      (res_valid),
    .res_from_pc    (res_from_pc),
    .res_to_pc      (res_to_pc),
    .res_taken      (res_taken),
    .res_pred_pc    (res_pred_pc),
    .res_ready      (res_ready),
    .inv_req        (inv_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .btb_wr_en      (btb_wr_en),
    .btb_wr_idx     (btb_wr_idx),
    .btb_wr_data    (btb_wr_data),
    .busy           (busy),
    .stat_resolved  (stat_resolved),
    .stat_mispred   (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp(input int v);
`ifdef BTB_CTRL_STATS_EN
    return 16'(v);
`else
    return 16'd0 & 16'(v);
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one resolution, wait (bounded) for acceptance, record expectations.
  task automatic resolve(input logic [15:0] from, input logic [15:0] to,
                         input logic taken, input logic [15:0] pred);
    logic [15:0] act;
    int waited = 0;
    res_valid   = 1'b1;
    res_from_pc = from;
    res_to_pc   = to;
    res_taken   = taken;
    res_pred_pc = pred;
    act = taken ? to : from + 16'd4;
    while (!res_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check_eq("res_ready_timeout", res_ready, 1);
    exp_res++;
    if (act != pred) begin
      exp_mis++;
      redir_q.push_back(act);
      wr_q.push_back('{idx: from[5:2], data: (taken ? to : 16'h0001)});
    end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic start_sweep();
    busy_cycles = 0;
    inv_req = 1'b1;
    for (int i = 0; i < 16; i++) wr_q.push_back('{idx: 4'(i), data: 16'h0001});
    @(negedge clk);
    inv_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {redirect_valid, flush_if, btb_wr_en, busy}, 0);
    check_eq({tag, "_redir_pc"}, redirect_pc, 0);
    check_eq({tag, "_wr_idx_data"}, {btb_wr_idx, btb_wr_data}, 0);
    check_eq({tag, "_stats"}, {stat_resolved, stat_mispred}, 0);
  endtask

  // Scoreboard monitor, sampling between active edges.
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (redirect_valid || flush_if) begin
      if (redir_q.size() == 0) begin
        check_eq("redir_unexpected", {redirect_valid, flush_if}, 0);
      end else begin
        mon_pc = redir_q.pop_front();
        check_eq("redir_pc", redirect_pc, mon_pc);
        check_eq("redir_flush", {redirect_valid, flush_if}, 2'b11);
      end
    end
    if (btb_wr_en) begin
      if (wr_q.size() == 0) begin
        check_eq("wr_unexpected", btb_wr_en, 0);
      end else begin
        mon_wr = wr_q.pop_front();
        check_eq("wr_idx", btb_wr_idx, mon_wr.idx);
        check_eq("wr_data", btb_wr_data, mon_wr.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; res_valid = 1'b0; inv_req = 1'b0; res_taken = 1'b0;
    res_from_pc = '0; res_to_pc = '0; res_pred_pc = '0;
    cycles(2);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", res_ready, 1);

    // Taken mispredict: redirect and write both one cycle after acceptance.
    resolve(16'h0010, 16'h0040, 1'b1, 16'h0014);
    check_eq("lat_redirect", redirect_valid, 1);
    check_eq("lat_wr", btb_wr_en, 1);
    cycles(2);

    // Not-taken mispredict: stale entry invalidated.
    resolve(16'h0020, 16'h0000, 1'b0, 16'h0080);
    cycles(2);

    // Correct prediction: nothing happens.
    resolve(16'h00F0, 16'h0100, 1'b1, 16'h0100);
    check_eq("correct_no_redir", redirect_valid, 0);
    check_eq("correct_no_wr", btb_wr_en, 0);
    check_eq("correct_stat_mis", stat_mispred, stat_exp(exp_mis));
    cycles(2);

    // Sweep with three mispredicts arriving during it; inv_req during sweep ignored.
    start_sweep();
    check_eq("sweep_first", {busy, btb_wr_en, btb_wr_idx}, {1'b1, 1'b1, 4'd0});
    resolve(16'h0030, 16'h0050, 1'b1, 16'h0034);
    resolve(16'h0044, 16'h0000, 1'b0, 16'h0090);
    check_eq("ready_full", res_ready, 0);
    inv_req = 1'b1;
    @(negedge clk);
    inv_req = 1'b0;
    resolve(16'h0058, 16'h0200, 1'b1, 16'h005C);
    cycles(4);
    check_eq("busy_cycles", busy_cycles, 16);
    check_eq("sweep_wr_drained", wr_q.size(), 0);
    check_eq("sweep_redir_drained", redir_q.size(), 0);

    // Address wrap on fall-through.
    resolve(16'hFFFC, 16'h0000, 1'b0, 16'h1234);
    check_eq("wrap_pc", {redirect_valid, redirect_pc}, {1'b1, 16'h0000});
    cycles(2);

    // Reset mid-sweep discards the rest of the sweep.
    start_sweep();
    cycles(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    wr_q.delete();
    redir_q.delete();
    exp_res = 0;
    exp_mis = 0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_mid");
    check_eq("rst_mid_ready", res_ready, 1);
    cycles(20);

    // Five resolutions, two of them mispredicted.
    resolve(16'h0060, 16'h0000, 1'b0, 16'h0064);
    resolve(16'h00A0, 16'h0400, 1'b1, 16'h00A4);
    resolve(16'h0070, 16'h0300, 1'b1, 16'h0300);
    resolve(16'h00B0, 16'h0000, 1'b0, 16'h0500);
    resolve(16'h0080, 16'h0000, 1'b0, 16'h0084);
    cycles(4);
    check_eq("stat_resolved", stat_resolved, stat_exp(exp_res));
    check_eq("stat_mispred", stat_mispred, stat_exp(exp_mis));
    check_eq("final_wr_drained", wr_q.size(), 0);
    check_eq("final_redir_drained", redir_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
